// File: rtl/sseg_pkg.sv
// Shared constants, state encoding and digit-count helpers for the
// seven-segment display formatter.
package sseg_pkg;

    localparam logic [15:0] MAX_NUM = 16'd9999;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLAMP,
        ST_SCAN,
        ST_COMMIT
    } state_t;

    // Thresholds walked during the scan, most significant digit first.
    function automatic logic [15:0] scan_thresh(input logic [1:0] idx);
        case (idx)
            2'd0:    return 16'd1000;
            2'd1:    return 16'd100;
            default: return 16'd10;
        endcase
    endfunction

    // Digits needed so that the highest lit decimal point lands on a shown digit.
    function automatic logic [2:0] dp_digits(input logic [3:0] dp);
        if (dp[3])      return 3'd4;
        else if (dp[2]) return 3'd3;
        else if (dp[1]) return 3'd2;
        else if (dp[0]) return 3'd1;
        else            return 3'd0;
    endfunction

    function automatic logic [3:0] digit_mask(input logic [2:0] n);
        case (n)
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            3'd4:    return 4'b1111;
            default: return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/sseg_display_formatter_if.sv
// Producer-side valid/ready word carrying the value, decimal-point mask
// and display options.
interface sseg_display_formatter_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic [3:0]  in_dp;
    logic        in_blank_lz;
    logic        in_blink;

    modport master (
        output in_valid, in_value, in_dp, in_blank_lz, in_blink,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_value, in_dp, in_blank_lz, in_blink,
        output in_ready
    );
endinterface

// File: rtl/sseg_blink_gen.sv
// Free-running blink counter; phase is its top bit, so it toggles every
// 2^(BLINK_DIV_BIT-1) cycles.
module sseg_blink_gen #(
    parameter int BLINK_DIV_BIT = 24
) (
    input  logic clk,
    input  logic rst,
    output logic phase
);
    localparam logic [BLINK_DIV_BIT-1:0] ONE = {{(BLINK_DIV_BIT-1){1'b0}}, 1'b1};

    logic [BLINK_DIV_BIT-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= count + ONE;
    end

    assign phase = count[BLINK_DIV_BIT-1];
endmodule

// File: rtl/sseg_display_formatter.sv
// Formats one accepted word into num/dig_en/dp_en for the 4-digit display
// controller: clamp, leading-zero scan, atomic commit, then blink gating.
module sseg_display_formatter
    import sseg_pkg::*;
#(
    parameter int BLINK_DIV_BIT = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    sseg_display_formatter_if.slave  bus,
    output logic [13:0]              num,
    output logic [3:0]               dig_en,
    output logic [3:0]               dp_en,
    output logic                     ovf
);
    state_t state, next_state;

    logic [15:0] lat_value;
    logic [3:0]  lat_dp;
    logic        lat_blank_lz;
    logic        lat_blink;
    logic [13:0] v;
    logic        ovf_nxt;
    logic [1:0]  scan_idx;
    logic [2:0]  n_cnt;
    logic [2:0]  n_final;
    logic [3:0]  base_en;
    logic [3:0]  dp_reg;
    logic        blink_en;
    logic        phase;

    sseg_blink_gen #(.BLINK_DIV_BIT(BLINK_DIV_BIT)) u_blink (
        .clk   (clk),
        .rst   (rst),
        .phase (phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        bus.in_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) next_state = ST_CLAMP;
            end
            ST_CLAMP:  next_state = ST_SCAN;
            ST_SCAN:   if (scan_idx == 2'd2) next_state = ST_COMMIT;
            ST_COMMIT: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // A lit decimal point forces enough digits on to be visible.
    always_comb begin
        n_final = n_cnt;
        if (dp_digits(lat_dp) > n_cnt) n_final = dp_digits(lat_dp);
    end

    // The first threshold met fixes the digit count; later ones cannot lower it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_value    <= '0;
            lat_dp       <= '0;
            lat_blank_lz <= 1'b0;
            lat_blink    <= 1'b0;
            v            <= '0;
            ovf_nxt      <= 1'b0;
            scan_idx     <= '0;
            n_cnt        <= 3'd1;
            num          <= '0;
            base_en      <= 4'b0001;
            dp_reg       <= '0;
            ovf          <= 1'b0;
            blink_en     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        lat_value    <= bus.in_value;
                        lat_dp       <= bus.in_dp;
                        lat_blank_lz <= bus.in_blank_lz;
                        lat_blink    <= bus.in_blink;
                    end
                end
                ST_CLAMP: begin
                    if (lat_value > MAX_NUM) begin
                        v       <= MAX_NUM[13:0];
                        ovf_nxt <= 1'b1;
                    end else begin
                        v       <= lat_value[13:0];
                        ovf_nxt <= 1'b0;
                    end
                    n_cnt    <= 3'd1;
                    scan_idx <= '0;
                end
                ST_SCAN: begin
                    if (n_cnt == 3'd1 && {2'b00, v} >= scan_thresh(scan_idx))
                        n_cnt <= 3'd4 - {1'b0, scan_idx};
                    scan_idx <= scan_idx + 2'd1;
                end
                ST_COMMIT: begin
                    num      <= v;
                    dp_reg   <= lat_dp;
                    ovf      <= ovf_nxt;
                    blink_en <= lat_blink;
                    base_en  <= lat_blank_lz ? digit_mask(n_final) : 4'b1111;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dig_en = base_en;
        dp_en  = dp_reg;
        if ((blink_en | ovf) & phase) begin
            dig_en = 4'b0000;
            dp_en  = 4'b0000;
        end
    end
endmodule
